eth_tx_pacer: RTL
=================

# eth_tx_pacer

Parametrised transmit pacing and PHY bring-up controller for the RGMII Ethernet TX path, sitting beside `ethernet_tx` in the 125 MHz domain. It replaces the fixed-ratio byte-advance counter and the PHY reset counter with configurable dividers and reset timing. It adds debounced link-speed selection, which is deferred while a frame is in flight, and inter-frame-gap (IFG) enforcement. Its outputs drive `adv_data` into the byte source and `phy_ready` into `ethernet_tx`.

## Interface
Parameters:
- `DIV_W`, 8: width of the advance divider counter.
- `DIV_100M`, 10: clk125MHz cycles per advance strobe at 100 Mb/s. Range 2..2^DIV_W-1.
- `DIV_10M`, 100: cycles per advance strobe at 10 Mb/s. Range 2..2^DIV_W-1.
- `RST_LOW`, 8388608: cycles `eth_rst_b` is held low after reset.
- `RST_WAIT`, 8388608: cycles from `eth_rst_b` rising to `phy_ready` rising.
- `LINK_STABLE`, 1024: consecutive cycles a new speed candidate must persist before it is adopted. Minimum 1.
- `IFG_BYTES`, 12: minimum gap between frames, counted in advance strobes.

Ports:
- `clk125MHz` in 1: the only clock.
- `rstb` in 1: reset, asynchronous and active-high.
- `link_10mb`, `link_100mb`, `link_1000mb` in 1 each: link status from `rgmii_rx`. These are asynchronous to this block.
- `frame_active` in 1: high while the TX byte source is inside a frame (the `raw_data_enable` of the byte source).
- `eth_rst_b` out 1: PHY reset, active-low.
- `phy_ready` out 1: the PHY reset sequence has completed.
- `speed` out 2: 11 = 1000, 10 = 100, 01 = 10, 00 = reserved.
- `adv_data` out 1: one-cycle advance strobe to the byte source.
- `ifg_ok` out 1: a new frame may start.
- `speed_changed` out 1: one-cycle pulse when `speed` updates.

## Operation
- **Reset values** (`rstb`=1, asynchronous): `eth_rst_b`=0, `phy_ready`=0, `speed`=11, `adv_data`=0, `ifg_ok`=0, `speed_changed`=0. All counters are 0, and the FSM is in S_RST.
- **PHY FSM:**
  - S_RST: `eth_rst_b`=0. Count `RST_LOW` cycles, then go to S_WAIT.
  - S_WAIT: `eth_rst_b`=1. Count `RST_WAIT` cycles, then go to S_READY.
  - S_READY: `eth_rst_b`=1 and `phy_ready`=1. This state is terminal.
  - Asserting `rstb` at any time returns the FSM to S_RST immediately, even mid-frame.
- **Link synchronisation:** each link input passes through a 2-flop synchroniser.
- **Candidate speed:** priority is 1000 > 100 > 10. If no link input is asserted, the candidate equals the current `speed`, so the last speed is held.
- **Stability counter:**
  - The counter increments while the candidate differs from `speed` and is unchanged from the previous cycle.
  - It restarts at 1 when the candidate changes, and clears when the candidate equals `speed`.
  - It saturates at `LINK_STABLE`.
- **Speed adoption:** when the stability counter equals `LINK_STABLE` and `frame_active`=0, `speed` takes the candidate on the next edge and `speed_changed` pulses for that cycle. If `frame_active`=1, adoption waits for the first cycle with `frame_active`=0.
- **Advance divider:** counts only in S_READY and resets to 0 when `speed` changes.
  - `speed` 11: `adv_data`=1 on every S_READY cycle.
  - `speed` 10: counter runs 0..`DIV_100M`-1 and wraps; `adv_data`=1 when the counter is 0.
  - `speed` 01: counter runs 0..`DIV_10M`-1 and wraps; `adv_data`=1 when the counter is 0.
  - `speed` 00: `adv_data` stays 0.
  - `adv_data` is always 0 outside S_READY.
- **IFG counter:**
  - Cleared to 0 whenever `frame_active`=1.
  - Otherwise increments on each `adv_data` strobe and saturates at `IFG_BYTES`.
  - `ifg_ok` = `phy_ready` AND (count == `IFG_BYTES`), registered.
  - On entry to S_READY the counter is preloaded with `IFG_BYTES`, so `ifg_ok` is available immediately.
  - A speed change does not clear the counter.
- **Simultaneous events:** if `frame_active` rises in the same cycle the stability counter saturates, adoption is deferred. If `rstb` coincides with any event, `rstb` wins.

## Timing
- `eth_rst_b` rises `RST_LOW` cycles after `rstb` falls.
- `phy_ready` rises `RST_WAIT` cycles after `eth_rst_b` rises.
- `adv_data` is registered:
  - The first strobe at 1000 Mb/s occurs on the first S_READY cycle.
  - At divided speeds, strobes follow one cycle after a divider-counter value of 0.
  - Strobe period is exactly `DIV_x` cycles, and the duty cycle is 1 cycle.
- A link input change reaches `speed` after 2 (synchroniser) + `LINK_STABLE` + 1 cycles, provided `frame_active`=0.
- `speed_changed` is high in the first cycle `speed` shows its new value.
- `ifg_ok` falls 1 cycle after `frame_active` rises. It rises 1 cycle after the `IFG_BYTES`-th strobe that follows `frame_active` falling.

## Test plan
All scenarios use RST_LOW=16, RST_WAIT=8, LINK_STABLE=4, DIV_100M=10, DIV_10M=100, IFG_BYTES=12.
- **Bring-up:** release `rstb` at t0 with `link_1000mb`=1. Require `eth_rst_b` rising at t0+16, `phy_ready` and `ifg_ok` rising at t0+24, and `adv_data` continuously 1.
- **Speed downgrade:** with the PHY ready, switch link inputs from 1000 to 100. Require `speed`=10 and a single `speed_changed` pulse 7 cycles later. After that, `adv_data` pulses every 10 cycles; repeat with `link_10mb` and require a 100-cycle period.
- **Glitch rejection:** pulse `link_100mb` high for 3 cycles while `speed`=11. Require `speed` to stay 11 and `speed_changed` to never pulse.
- **Deferred change:** change the link to 10 Mb/s while `frame_active`=1, and hold `frame_active` 50 more cycles. Require `speed` to update on the cycle after `frame_active` falls, not before.
- **IFG:** drop `frame_active` at 100 Mb/s. Require `ifg_ok`=0 for 12 strobes (about 120 cycles), then 1. Re-asserting `frame_active` mid-gap must restart the count from 0.
- **Reset mid-operation:** assert `rstb` during a frame at 100 Mb/s. Require all outputs to return to reset values asynchronously and `speed`=11, followed by the full bring-up sequence.

Source files
------------

// File: rtl/eth_tx_pacer.sv
// eth_tx_pacer: transmit pacing and PHY bring-up controller for the RGMII TX path.
//
// Sequences the PHY reset, selects the link speed from debounced link status,
// produces the byte-advance strobe for the TX byte source and enforces the
// inter-frame gap.
//
// Ports:
//   clk125MHz      in   the only clock
//   rstb           in   asynchronous active-high reset
//   link_10mb      in   link status from rgmii_rx (asynchronous)
//   link_100mb     in   link status from rgmii_rx (asynchronous)
//   link_1000mb    in   link status from rgmii_rx (asynchronous)
//   frame_active   in   high while the byte source is inside a frame
//   eth_rst_b      out  PHY reset, active-low
//   phy_ready      out  PHY reset sequence complete
//   speed          out  11 = 1000, 10 = 100, 01 = 10, 00 = reserved
//   adv_data       out  one-cycle advance strobe to the byte source
//   ifg_ok         out  a new frame may start
//   speed_changed  out  one-cycle pulse in the first cycle of a new speed
module eth_tx_pacer #(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DIV_100M    = 10,
   parameter int unsigned DIV_10M     = 100,
   parameter int unsigned RST_LOW     = 8388608,
   parameter int unsigned RST_WAIT    = 8388608,
   parameter int unsigned LINK_STABLE = 1024,
   parameter int unsigned IFG_BYTES   = 12
) (
   input  logic       clk125MHz,
   input  logic       rstb,
   input  logic       link_10mb,
   input  logic       link_100mb,
   input  logic       link_1000mb,
   input  logic       frame_active,
   output logic       eth_rst_b,
   output logic       phy_ready,
   output logic [1:0] speed,
   output logic       adv_data,
   output logic       ifg_ok,
   output logic       speed_changed
);

   localparam int unsigned RST_MAX = (RST_LOW > RST_WAIT) ? RST_LOW : RST_WAIT;
   localparam int unsigned RST_CW  = $clog2(RST_MAX + 1);
   localparam int unsigned STAB_W  = $clog2(LINK_STABLE + 1);
   localparam int unsigned IFG_W   = (IFG_BYTES > 0) ? $clog2(IFG_BYTES + 1) : 1;

   localparam logic [RST_CW-1:0] RST_LOW_LAST  = RST_CW'(RST_LOW - 1);
   localparam logic [RST_CW-1:0] RST_WAIT_LAST = RST_CW'(RST_WAIT - 1);
   localparam logic [STAB_W-1:0] STAB_MAX      = STAB_W'(LINK_STABLE);
   localparam logic [IFG_W-1:0]  IFG_MAX       = IFG_W'(IFG_BYTES);
   localparam logic [DIV_W-1:0]  DIV100_LAST   = DIV_W'(DIV_100M - 1);
   localparam logic [DIV_W-1:0]  DIV10_LAST    = DIV_W'(DIV_10M - 1);

   localparam logic [1:0] SPD_1000 = 2'b11;
   localparam logic [1:0] SPD_100  = 2'b10;
   localparam logic [1:0] SPD_10   = 2'b01;

   typedef enum logic [1:0] {StRst, StWait, StReady} state_e;

   state_e            state_q, state_d;
   logic [RST_CW-1:0] rst_cnt_q, rst_cnt_d;
   logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]        speed_q, speed_d, cand_prev_q, cand_prev_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              changed_q, changed_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              adv_q, adv_d;
   logic [IFG_W-1:0]  ifg_q, ifg_d;
   logic              ifg_ok_q, ifg_ok_d;

   logic [1:0]       cand;
   logic             adopt;
   logic             is_ready;
   logic             go_ready;
   logic [DIV_W-1:0] div_last;

   // PHY reset sequencer
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      unique case (state_q)
         StRst: begin
            if (rst_cnt_q == RST_LOW_LAST) begin
               state_d   = StWait;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_CW'(1);
            end
         end
         StWait: begin
            if (rst_cnt_q == RST_WAIT_LAST) begin
               state_d   = StReady;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_CW'(1);
            end
         end
         StReady: begin
            state_d = StReady;
         end
         default: begin
            state_d   = StRst;
            rst_cnt_d = '0;
         end
      endcase
   end

   assign is_ready = (state_q == StReady);
   assign go_ready = (state_d == StReady);

   // Link synchronisers, bit 2 = 1000, bit 1 = 100, bit 0 = 10
   assign sync1_d = {link_1000mb, link_100mb, link_10mb};
   assign sync2_d = sync1_q;

   // Candidate selection, debounce and deferred adoption
   always_comb begin
      if (sync2_q[2]) begin
         cand = SPD_1000;
      end else if (sync2_q[1]) begin
         cand = SPD_100;
      end else if (sync2_q[0]) begin
         cand = SPD_10;
      end else begin
         cand = speed_q;  // no link: hold the last speed
      end

      adopt       = (stab_q == STAB_MAX) && !frame_active && (cand != speed_q);
      speed_d     = adopt ? cand : speed_q;
      changed_d   = adopt;
      cand_prev_d = cand;

      if (adopt || (cand == speed_q)) begin
         stab_d = '0;
      end else if (cand != cand_prev_q) begin
         stab_d = STAB_W'(1);
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + STAB_W'(1);
      end else begin
         stab_d = stab_q;
      end
   end

   // Advance divider and strobe
   always_comb begin
      div_last = (speed_q == SPD_100) ? DIV100_LAST : DIV10_LAST;
      div_d    = div_q;
      adv_d    = 1'b0;

      if (adopt) begin
         div_d = '0;
      end else if (is_ready && ((speed_q == SPD_100) || (speed_q == SPD_10))) begin
         div_d = (div_q == div_last) ? '0 : div_q + DIV_W'(1);
      end

      unique case (speed_q)
         SPD_1000:       adv_d = go_ready;  // strobe already on the first ready cycle
         SPD_100, SPD_10: adv_d = is_ready && (div_q == '0);
         default:        adv_d = 1'b0;
      endcase
   end

   // Inter-frame gap, counted in advance strobes
   always_comb begin
      ifg_d = ifg_q;
      if (frame_active) begin
         ifg_d = '0;
      end else if (go_ready && !is_ready) begin
         ifg_d = IFG_MAX;  // preload so the first frame need not wait
      end else if (adv_q && (ifg_q != IFG_MAX)) begin
         ifg_d = ifg_q + IFG_W'(1);
      end
      ifg_ok_d = go_ready && (ifg_d == IFG_MAX);
   end

   always_ff @(posedge clk125MHz or posedge rstb) begin
      if (rstb) begin
         state_q     <= StRst;
         rst_cnt_q   <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         speed_q     <= SPD_1000;
         cand_prev_q <= SPD_1000;
         stab_q      <= '0;
         changed_q   <= 1'b0;
         div_q       <= '0;
         adv_q       <= 1'b0;
         ifg_q       <= '0;
         ifg_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         speed_q     <= speed_d;
         cand_prev_q <= cand_prev_d;
         stab_q      <= stab_d;
         changed_q   <= changed_d;
         div_q       <= div_d;
         adv_q       <= adv_d;
         ifg_q       <= ifg_d;
         ifg_ok_q    <= ifg_ok_d;
      end
   end

   assign eth_rst_b     = (state_q != StRst);
   assign phy_ready     = is_ready;
   assign speed         = speed_q;
   assign adv_data      = adv_q;
   assign ifg_ok        = ifg_ok_q;
   assign speed_changed = changed_q;

endmodule
